// File: rtl/bram_dualport.sv
// True dual-port block RAM: two independent read/write ports on one clock,
// byte write enables, selectable same-port write behaviour and an optional output register.
module bram_dualport #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int WRITE_MODE = 0,
   parameter int OUT_REG    = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    a_en,
   input  logic [DATA_WIDTH/8-1:0] a_we,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic [DATA_WIDTH-1:0]   a_din,
   output logic [DATA_WIDTH-1:0]   a_dout,
   output logic                    a_valid,
   input  logic                    b_en,
   input  logic [DATA_WIDTH/8-1:0] b_we,
   input  logic [ADDR_WIDTH-1:0]   b_addr,
   input  logic [DATA_WIDTH-1:0]   b_din,
   output logic [DATA_WIDTH-1:0]   b_dout,
   output logic                    b_valid
);
   localparam int          NB      = DATA_WIDTH / 8;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum int {
      READ_FIRST  = 0,
      WRITE_FIRST = 1,
      NO_CHANGE   = 2
   } write_mode_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   logic [1:0]            en;
   logic [NB-1:0]         we       [2];
   logic [ADDR_WIDTH-1:0] addr     [2];
   logic [DATA_WIDTH-1:0] din      [2];
   logic [1:0]            in_range;
   logic [DATA_WIDTH-1:0] rd_old   [2];
   logic [DATA_WIDTH-1:0] rd_new   [2];
   logic [NB-1:0]         wr_bytes [2];
   logic [DATA_WIDTH-1:0] s1_data  [2];
   logic [1:0]            s1_valid;

   assign en      = {b_en, a_en};
   assign we[0]   = a_we;
   assign we[1]   = b_we;
   assign addr[0] = a_addr;
   assign addr[1] = b_addr;
   assign din[0]  = a_din;
   assign din[1]  = b_din;

   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         in_range[p] = 32'(addr[p]) < DEPTH_W;
         rd_old[p]   = in_range[p] ? mem[addr[p]] : '0;
         wr_bytes[p] = (en[p] && rst_n && in_range[p]) ? we[p] : '0;
         rd_new[p]   = rd_old[p];
         for (int unsigned k = 0; k < NB; k++) begin
            if (we[p][k]) rd_new[p][8*k +: 8] = din[p][8*k +: 8];
         end
         if (!in_range[p]) rd_new[p] = '0;
      end
   end

   // Port A is written last so it wins any byte both ports enable at one address.
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < NB; k++) begin
         if (wr_bytes[1][k]) mem[addr[1]][8*k +: 8] <= din[1][8*k +: 8];
         if (wr_bytes[0][k]) mem[addr[0]][8*k +: 8] <= din[0][8*k +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= '0;
         for (int unsigned p = 0; p < 2; p++) s1_data[p] <= '0;
      end else begin
         for (int unsigned p = 0; p < 2; p++) begin
            s1_valid[p] <= en[p];
            if (en[p]) begin
               if (we[p] == '0 || WRITE_MODE == READ_FIRST) s1_data[p] <= rd_old[p];
               else if (WRITE_MODE == WRITE_FIRST)          s1_data[p] <= rd_new[p];
            end
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data [2];
      logic [1:0]            s2_valid;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s2_valid <= '0;
            for (int unsigned p = 0; p < 2; p++) s2_data[p] <= '0;
         end else begin
            s2_valid <= s1_valid;
            for (int unsigned p = 0; p < 2; p++) s2_data[p] <= s1_data[p];
         end
      end

      assign a_dout  = s2_data[0];
      assign b_dout  = s2_data[1];
      assign a_valid = s2_valid[0];
      assign b_valid = s2_valid[1];
   end else begin : g_no_out_reg
      assign a_dout  = s1_data[0];
      assign b_dout  = s1_data[1];
      assign a_valid = s1_valid[0];
      assign b_valid = s1_valid[1];
   end

endmodule
